bp_cache_dma_to_sram: RTL

Memory-side endpoint for the cache DMA interface: consumes the block-granular DMA packets and write beats produced by the CCE-to-cache-DMA bridge and services them against a synchronous single-port SRAM with 1-cycle read latency. Read data is returned as dword beats on the DMA read-data channel. It sits directly downstream of the CCE-to-cache-DMA bridge, and is used as the off-chip memory stand-in in FPGA and simulation builds.

---
 rtl/bp_cache_dma_to_sram_pkg.sv | 19 +
 rtl/bp_cache_dma_to_sram_if.sv | 40 ++++
 rtl/bp_cache_dma_to_sram_two_fifo.sv | 46 ++++
 rtl/bp_cache_dma_to_sram.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/bp_cache_dma_to_sram_pkg.sv
// Shared types and constants for the cache-DMA to SRAM endpoint.
//   bp_cache_dma_sram_state_e    : request FSM state
//   bp_cache_dma_sram_credits_gp : read return buffering depth (FIFO entries)
//   bsg_cache_dma_pkt_width()    : packed width of {write_not_read, addr}
package bp_cache_dma_sram_pkg;

  typedef enum logic [1:0] {
    e_idle  = 2'd0,
    e_write = 2'd1,
    e_read  = 2'd2
  } bp_cache_dma_sram_state_e;

  localparam int unsigned bp_cache_dma_sram_credits_gp = 2;

  function automatic int bsg_cache_dma_pkt_width(input int paddr_width);
    return paddr_width + 1;
  endfunction

endpackage

// File: rtl/bp_cache_dma_to_sram_if.sv
// DMA + SRAM signal bundle for bp_cache_dma_to_sram.
//   slave  : the endpoint (consumes packets/write beats, drives SRAM, returns read beats)
//   master : the environment (bridge + SRAM macro)
// dma_pkt_i is {write_not_read, addr[paddr_width_p-1:0]}.
interface bp_cache_dma_to_sram_if #(
  parameter int paddr_width_p = 40,
  parameter int dword_width_p = 64,
  parameter int mem_els_p     = 2**20
);
  import bp_cache_dma_sram_pkg::*;
  localparam int lg_mem_els_lp = $clog2(mem_els_p);

  logic [bsg_cache_dma_pkt_width(paddr_width_p)-1:0] dma_pkt_i;
  logic                     dma_pkt_v_i;
  logic                     dma_pkt_yumi_o;
  logic [dword_width_p-1:0] dma_data_i;
  logic                     dma_data_v_i;
  logic                     dma_data_yumi_o;
  logic [dword_width_p-1:0] dma_data_o;
  logic                     dma_data_v_o;
  logic                     dma_data_ready_i;
  logic                     mem_v_o;
  logic                     mem_w_o;
  logic [lg_mem_els_lp-1:0] mem_addr_o;
  logic [dword_width_p-1:0] mem_data_o;
  logic [dword_width_p-1:0] mem_data_i;

  modport slave (
    input  dma_pkt_i, dma_pkt_v_i, dma_data_i, dma_data_v_i, dma_data_ready_i, mem_data_i,
    output dma_pkt_yumi_o, dma_data_yumi_o, dma_data_o, dma_data_v_o,
           mem_v_o, mem_w_o, mem_addr_o, mem_data_o
  );

  modport master (
    output dma_pkt_i, dma_pkt_v_i, dma_data_i, dma_data_v_i, dma_data_ready_i, mem_data_i,
    input  dma_pkt_yumi_o, dma_data_yumi_o, dma_data_o, dma_data_v_o,
           mem_v_o, mem_w_o, mem_addr_o, mem_data_o
  );

endinterface

// File: rtl/bp_cache_dma_to_sram_two_fifo.sv
// bsg_two_fifo: 2-entry ready/valid FIFO holding SRAM read returns.
//   clk_i, reset_n_i (async, active-low)
//   v_i/data_i/ready_o : enqueue side
//   v_o/data_o/yumi_i  : dequeue side (yumi_i only while v_o)
module bsg_two_fifo #(
  parameter int width_p = 64
) (
  input  logic               clk_i,
  input  logic               reset_n_i,
  output logic               ready_o,
  input  logic [width_p-1:0] data_i,
  input  logic               v_i,
  output logic               v_o,
  output logic [width_p-1:0] data_o,
  input  logic               yumi_i
);

  logic [1:0][width_p-1:0] mem_r;
  logic                    rptr_r, wptr_r;
  logic [1:0]              count_r;
  logic                    enq, deq;

  assign ready_o = (count_r != 2'd2);
  assign v_o     = (count_r != 2'd0);
  assign enq     = v_i & ready_o;
  assign deq     = yumi_i & v_o;
  assign data_o  = mem_r[rptr_r];

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      rptr_r  <= 1'b0;
      wptr_r  <= 1'b0;
      count_r <= 2'd0;
    end else begin
      rptr_r  <= rptr_r ^ deq;
      wptr_r  <= wptr_r ^ enq;
      count_r <= count_r + {1'b0, enq} - {1'b0, deq};
    end
  end

  // Storage needs no reset: count_r gates visibility.
  always_ff @(posedge clk_i) begin
    if (enq) mem_r[wptr_r] <= data_i;
  end

endmodule

// File: rtl/bp_cache_dma_to_sram.sv
// bp_cache_dma_to_sram: memory-side endpoint of the cache DMA interface.
// Accepts block packets, writes incoming beats to a 1-cycle-latency
// single-port SRAM, and streams read blocks back as dword beats through a
// 2-entry return FIFO under credit control.
//   clk_i, reset_n_i : clock, async active-low reset
//   dma (slave)      : DMA packet / write beat / read beat channels + SRAM port
//   error_o          : sticky out-of-range flag
// Optional build macro BP_CACHE_DMA_SRAM_BOUNDS_CHECK_EN: flag and suppress
// accesses whose address lies beyond the SRAM; otherwise upper address
// bits alias and error_o is 0.
module bp_cache_dma_to_sram
  import bp_cache_dma_sram_pkg::*;
#(
  parameter int paddr_width_p         = 40,
  parameter int dword_width_p         = 64,
  parameter int block_size_in_words_p = 8,
  parameter int mem_els_p             = 2**20
) (
  input  logic                  clk_i,
  input  logic                  reset_n_i,
  bp_cache_dma_to_sram_if.slave dma,
  output logic                  error_o
);

  localparam int lg_mem_els_lp = $clog2(mem_els_p);
  localparam int lg_block_lp   = $clog2(block_size_in_words_p);

  typedef logic [lg_mem_els_lp-1:0] mem_addr_t;
  typedef logic [lg_block_lp-1:0]   cnt_t;

  bp_cache_dma_sram_state_e state_r, state_n;

  logic                     pkt_wnr;
  logic [paddr_width_p-1:0] pkt_addr;
  mem_addr_t                pkt_base, base_r;
  cnt_t                     count_r;
  logic                     last_beat;
  logic                     pkt_yumi, data_yumi, rd_issue;
  logic                     inflight_r, inflight_zero_r;
  logic                     oob_r;
  logic                     fifo_ready, fifo_v, fifo_deq;
  logic [dword_width_p-1:0] ret_data;
  logic [1:0]               fifo_occ;
  logic [2:0]               pending;
  logic                     credit_ok;
  logic                     unused_addr_bits;

  assign {pkt_wnr, pkt_addr} = dma.dma_pkt_i;
  // Byte address -> dword address, aligned down to the block.
  assign pkt_base  = {pkt_addr[lg_mem_els_lp+2:3+lg_block_lp], {lg_block_lp{1'b0}}};
  assign unused_addr_bits = ^{pkt_addr[2:0], pkt_addr[paddr_width_p-1:lg_mem_els_lp+3]};
  assign last_beat = (count_r == cnt_t'(block_size_in_words_p-1));

`ifdef BP_CACHE_DMA_SRAM_BOUNDS_CHECK_EN
  logic pkt_oob, error_r;
  assign pkt_oob = |pkt_addr[paddr_width_p-1:lg_mem_els_lp+3];

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      oob_r   <= 1'b0;
      error_r <= 1'b0;
    end else if (pkt_yumi) begin
      oob_r   <= pkt_oob;
      error_r <= error_r | pkt_oob;
    end
  end
  assign error_o = error_r;
`else
  assign oob_r   = 1'b0;
  assign error_o = 1'b0;
`endif

  // Credits count buffer slots still free after this cycle. A beat leaving
  // the FIFO this cycle frees its slot for a read issued now (its data lands
  // two edges later), which is what sustains one beat per cycle.
  assign fifo_occ  = !fifo_v ? 2'd0 : (fifo_ready ? 2'd1 : 2'd2);
  assign fifo_deq  = fifo_v & dma.dma_data_ready_i;
  assign pending   = 3'(fifo_occ) - 3'(fifo_deq) + 3'(inflight_r);
  assign credit_ok = (pending < 3'(bp_cache_dma_sram_credits_gp));

  // FSM: state register
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) state_r <= e_idle;
    else            state_r <= state_n;
  end

  // FSM: next state
  always_comb begin
    state_n = state_r;
    unique case (state_r)
      e_idle:  if (pkt_yumi)             state_n = pkt_wnr ? e_write : e_read;
      e_write: if (data_yumi & last_beat) state_n = e_idle;
      e_read:  if (rd_issue & last_beat)  state_n = e_idle;
      default:                            state_n = e_idle;
    endcase
  end

  // FSM: outputs. Packet yumi is gated by reset so it is low while held.
  always_comb begin
    pkt_yumi  = 1'b0;
    data_yumi = 1'b0;
    rd_issue  = 1'b0;
    unique case (state_r)
      e_idle:  pkt_yumi  = reset_n_i & dma.dma_pkt_v_i;
      e_write: data_yumi = dma.dma_data_v_i;
      e_read:  rd_issue  = credit_ok;
      default: ;
    endcase
  end

  assign dma.dma_pkt_yumi_o  = pkt_yumi;
  assign dma.dma_data_yumi_o = data_yumi;
  assign dma.mem_v_o         = (data_yumi | rd_issue) & ~oob_r;
  assign dma.mem_w_o         = data_yumi & ~oob_r;
  assign dma.mem_addr_o      = base_r + mem_addr_t'(count_r);  // wraps mod mem_els_p
  assign dma.mem_data_o      = dma.dma_data_i;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      base_r          <= '0;
      count_r         <= '0;
      inflight_r      <= 1'b0;
      inflight_zero_r <= 1'b0;
    end else begin
      if (pkt_yumi) begin
        base_r  <= pkt_base;
        count_r <= '0;
      end else if (data_yumi | rd_issue) begin
        count_r <= count_r + cnt_t'(1);
      end
      inflight_r      <= rd_issue;
      // Out-of-range reads skip the SRAM and return zero beats instead.
      inflight_zero_r <= rd_issue & oob_r;
    end
  end

  assign ret_data = inflight_zero_r ? '0 : dma.mem_data_i;

  // Credits guarantee a free slot whenever inflight_r is set.
  bsg_two_fifo #(.width_p(dword_width_p)) ret_fifo (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .ready_o   (fifo_ready),
    .data_i    (ret_data),
    .v_i       (inflight_r),
    .v_o       (fifo_v),
    .data_o    (dma.dma_data_o),
    .yumi_i    (fifo_deq)
  );

  assign dma.dma_data_v_o = fifo_v;

endmodule
